// File: rtl/qcl_debounce_sched.sv
// qcl_debounce_sched: multi-channel switch debouncer sharing a single
// qualification timer. A round-robin scheduler hands the timer to one channel
// with a pending level change; after 2^(width_p-1) stable cycles the new level
// is committed and reported on a valid/ready event port.
//
// state  | meaning
// IDLE   | no channel being qualified; look for a pending channel to grant
// TIMING | granted channel ch_q is being timed for stability
// EVENT  | level committed, event held on ev_* until ev_ready_i
module qcl_debounce_sched #(
  parameter int num_p    = 8,
  parameter int width_p  = 22,
  parameter int lg_num_p = $clog2(num_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [num_p-1:0]    i,
  output logic [num_p-1:0]    o,
  output logic                ev_v_o,
  output logic [lg_num_p-1:0] ev_id_o,
  output logic                ev_level_o,
  input  logic                ev_ready_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    EVENT  = 2'd2
  } state_e;

  localparam logic [width_p-1:0] term_c = width_p'((64'd1 << (width_p - 1)) - 64'd1);

  state_e              state_q, state_d;
  logic [num_p-1:0]    sync1_q, s_q, o_q, pending;
  logic [width_p-1:0]  timer_q;
  logic [lg_num_p-1:0] ch_q, last_grant_q, ev_id_q, grant_idx;
  logic                grant_found, ev_v_q, ev_level_q;
  logic                do_grant, do_commit, do_release, timer_inc, timer_clr;

  assign pending    = s_q ^ o_q;
  assign o          = o_q;
  assign ev_v_o     = ev_v_q;
  assign ev_id_o    = ev_id_q;
  assign ev_level_o = ev_level_q;
  assign busy_o     = (state_q != IDLE);

  // Round-robin search: first pending channel strictly after last_grant_q.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= num_p; k++) begin
      int j;
      j = int'(last_grant_q) + k;
      if (j >= num_p) j = j - num_p;
      if (!grant_found && pending[j]) begin
        grant_found = 1'b1;
        grant_idx   = lg_num_p'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_commit  = 1'b0;
    do_release = 1'b0;
    timer_inc  = 1'b0;
    timer_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          do_grant = 1'b1;
          state_d  = TIMING;
        end
      end
      TIMING: begin
        if (s_q[ch_q] == o_q[ch_q]) begin
          timer_clr = 1'b1;
          state_d   = IDLE;
        end else if (timer_q == term_c) begin
          do_commit = 1'b1;
          state_d   = EVENT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      EVENT: begin
        if (ev_ready_i) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronizers, shared timer, committed levels and event registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q      <= '0;
      s_q          <= '0;
      o_q          <= '0;
      timer_q      <= '0;
      ch_q         <= '0;
      last_grant_q <= '0;
      ev_v_q       <= 1'b0;
      ev_id_q      <= '0;
      ev_level_q   <= 1'b0;
    end else begin
      sync1_q <= i;
      s_q     <= sync1_q;
      if (do_grant) begin
        ch_q    <= grant_idx;
        timer_q <= '0;
      end else if (timer_inc) begin
        timer_q <= timer_q + 1'b1;
      end else if (timer_clr || do_commit) begin
        timer_q <= '0;
      end
      if (do_commit) begin
        o_q[ch_q]  <= ~o_q[ch_q];
        ev_v_q     <= 1'b1;
        ev_id_q    <= ch_q;
        ev_level_q <= ~o_q[ch_q];
      end
      if (do_release) begin
        ev_v_q       <= 1'b0;
        last_grant_q <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_qcl_debounce_sched.sv
// Bench for qcl_debounce_sched (num_p=4, width_p=4, window of 8 cycles).
// Directed scenarios plus a randomized phase, all compared cycle by cycle
// against a transaction-style reference model.
module tb_qcl_debounce_sched;

  localparam int NUM = 4;
  localparam int WID = 4;
  localparam int WIN = 1 << (WID - 1);

  logic           clk = 1'b0;
  logic           reset_i;
  logic [NUM-1:0] in_v;
  logic [NUM-1:0] o;
  logic           ev_v_o;
  logic [1:0]     ev_id_o;
  logic           ev_level_o;
  logic           rdy;
  logic           busy_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [NUM-1:0] m_dly [2];
  logic [NUM-1:0] m_o;
  int             m_gch;
  int             m_age;
  bit             m_ev;
  int             m_ev_id;
  bit             m_ev_lvl;
  int             m_last;

  int obs[$];

  qcl_debounce_sched #(.num_p(NUM), .width_p(WID)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .i(in_v),
    .o(o),
    .ev_v_o(ev_v_o),
    .ev_id_o(ev_id_o),
    .ev_level_o(ev_level_o),
    .ev_ready_i(rdy),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_dly[0] = '0;
    m_dly[1] = '0;
    m_o      = '0;
    m_gch    = -1;
    m_age    = 0;
    m_ev     = 0;
    m_ev_id  = 0;
    m_ev_lvl = 0;
    m_last   = 0;
  endtask

  // one clock edge of the model, given the inputs present at that edge
  task automatic model_edge(input logic [NUM-1:0] vi, input logic r);
    logic [NUM-1:0] s;
    s = m_dly[1];
    if (m_ev) begin
      if (r) begin
        m_ev   = 0;
        m_last = m_ev_id;
      end
    end else if (m_gch < 0) begin
      for (int k = 1; k <= NUM; k++) begin
        int c;
        c = (m_last + k) % NUM;
        if (m_gch < 0 && (s[c] != m_o[c])) begin
          m_gch = c;
          m_age = 0;
        end
      end
    end else begin
      if (s[m_gch] == m_o[m_gch]) begin
        m_gch = -1;
      end else if (m_age == WIN - 1) begin
        m_o[m_gch] = ~m_o[m_gch];
        m_ev       = 1;
        m_ev_id    = m_gch;
        m_ev_lvl   = m_o[m_gch];
        m_gch      = -1;
      end else begin
        m_age++;
      end
    end
    m_dly[1] = m_dly[0];
    m_dly[0] = vi;
  endtask

  task automatic tick();
    logic [NUM-1:0] ci;
    logic           cr;
    ci = in_v;
    cr = rdy;
    if (ev_v_o && cr) obs.push_back(int'(ev_id_o) * 2 + int'(ev_level_o));
    @(posedge clk);
    model_edge(ci, cr);
    #1;
    chk("o", 32'(o), 32'(m_o));
    chk("ev_v", 32'(ev_v_o), 32'(m_ev));
    chk("busy", 32'(busy_o), 32'(m_ev || (m_gch >= 0)));
    if (m_ev) begin
      chk("ev_id", 32'(ev_id_o), 32'(m_ev_id));
      chk("ev_level", 32'(ev_level_o), 32'(m_ev_lvl));
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // async reset asserted between edges; outputs must clear before any edge
  task automatic do_reset();
    #1;
    reset_i = 1'b1;
    #1;
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_ev_v", 32'(ev_v_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset_i = 1'b0;
    obs.delete();
  endtask

  initial begin
    int first_ev;
    int busy_seen;
    int found;
    int cnt;
    logic [1:0] cap_id;
    logic       cap_lvl;

    reset_i = 1'b1;
    in_v    = '0;
    rdy     = 1'b0;
    model_reset();
    #3;
    chk("init_o", 32'(o), 32'd0);
    chk("init_ev_v", 32'(ev_v_o), 32'd0);
    chk("init_ev_id", 32'(ev_id_o), 32'd0);
    chk("init_ev_level", 32'(ev_level_o), 32'd0);
    chk("init_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #2;
    reset_i = 1'b0;

    // clean step on channel 0: event on the 11th edge after the change
    in_v = 4'b0001;
    rdy  = 1'b1;
    first_ev = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ev_v_o && first_ev == 0) first_ev = n;
    end
    chk("t1_latency", 32'(first_ev), 32'd11);
    chk("t1_count", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) chk("t1_ev", 32'(obs[0]), 32'd1);
    chk("t1_o", 32'(o), 32'b0001);

    // short glitch on channel 2: timed, then dropped, no event
    do_reset();
    in_v = 4'b0100;
    busy_seen = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (busy_o) busy_seen = 1;
    end
    in_v = 4'b0000;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (busy_o) busy_seen = 1;
    end
    chk("t2_busy_seen", 32'(busy_seen), 32'd1);
    chk("t2_busy_end", 32'(busy_o), 32'd0);
    chk("t2_o", 32'(o), 32'd0);
    chk("t2_count", 32'(obs.size()), 32'd0);

    // all channels change together: round-robin order 1,2,3,0
    do_reset();
    in_v = 4'b1111;
    rdy  = 1'b1;
    ticks(60);
    chk("t3_count", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("t3_ev0", 32'(obs[0]), 32'd3);
      chk("t3_ev1", 32'(obs[1]), 32'd5);
      chk("t3_ev2", 32'(obs[2]), 32'd7);
      chk("t3_ev3", 32'(obs[3]), 32'd1);
    end
    chk("t3_o", 32'(o), 32'b1111);

    // backpressure: event payload frozen, next channel waits for handshake
    do_reset();
    in_v = 4'b0011;
    rdy  = 1'b0;
    found = 0;
    for (int n = 0; n < 30 && found == 0; n++) begin
      tick();
      if (ev_v_o) found = 1;
    end
    chk("t4_ev_seen", 32'(found), 32'd1);
    cap_id  = ev_id_o;
    cap_lvl = ev_level_o;
    chk("t4_first_id", 32'(cap_id), 32'd1);
    chk("t4_first_lvl", 32'(cap_lvl), 32'd1);
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("t4_hold_v", 32'(ev_v_o), 32'd1);
      chk("t4_hold_id", 32'(ev_id_o), 32'(cap_id));
      chk("t4_hold_lvl", 32'(ev_level_o), 32'(cap_lvl));
      chk("t4_hold_o", 32'(o), 32'b0010);
    end
    rdy = 1'b1;
    ticks(20);
    chk("t4_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) chk("t4_second", 32'(obs[1]), 32'd1);

    // reset mid-qualification of channel 2, then re-qualify after release
    in_v = 4'b0111;
    ticks(6);
    chk("t5_busy_pre", 32'(busy_o), 32'd1);
    do_reset();
    ticks(60);
    cnt = 0;
    foreach (obs[k]) if (obs[k] == 5) cnt++;
    chk("t5_ch2_events", 32'(cnt), 32'd1);
    chk("t5_o", 32'(o), 32'b0111);

    // press and release of channel 3
    do_reset();
    in_v = 4'b1000;
    ticks(20);
    chk("t6_o_pressed", 32'(o), 32'b1000);
    in_v = 4'b0000;
    ticks(40);
    chk("t6_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      chk("t6_press", 32'(obs[0]), 32'd7);
      chk("t6_release", 32'(obs[1]), 32'd6);
    end
    chk("t6_o_released", 32'(o), 32'd0);

    // randomized inputs and consumer readiness
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) in_v[$urandom_range(0, NUM - 1)] ^= 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
